// File: rtl/ps2_host_tx_if.sv
// Command handshake between the PS/2 host transmitter and its client:
// byte request in, completion/ACK/timeout pulses out.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       done;
  logic       ack_ok;
  logic       error;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, done, ack_ok, error
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, done, ack_ok, error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter driving PS2_CLK/PS2_DATA open-drain.
// Define PS2_HOST_TX_TIMEOUT_EN to enable the device-edge watchdog in XFER/WAIT_IDLE.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_TICKS = 120,
  parameter int unsigned TIMEOUT_TICKS = 15000
) (
  input  logic         clk,
  input  logic         nRESET,
  input  logic         clk_en,
  ps2_host_tx_if.slave tx,
  output logic         rx_inhibit,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);

  localparam int unsigned IW = $clog2(INHIBIT_TICKS + 1);

  typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_START, S_XFER, S_WAIT_IDLE} state_t;

  state_t        state_q, state_d;
  logic          clk_s1_q, clk_s2_q, clk_prev_q, data_s1_q, data_s2_q;
  logic [IW-1:0] inh_q, inh_d;
  logic [8:0]    shift_q, shift_d;
  logic [3:0]    edges_q, edges_d;
  logic          clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic          done_q, done_d, ack_q, ack_d, err_q, err_d;
  logic          fall, tmo_hit;

  // Lines idle high, so synchronizers reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= ps2_data_in;
      data_s2_q  <= data_s1_q;
    end
  end

  assign fall = clk_prev_q & ~clk_s2_q;

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_run;

  assign tmo_run = (state_q == S_XFER) || (state_q == S_WAIT_IDLE);

  // A device edge restarts the window and takes priority over expiry.
  always_comb begin
    tmo_d   = tmo_q;
    tmo_hit = 1'b0;
    if (!tmo_run || fall) begin
      tmo_d = '0;
    end else if (clk_en) begin
      if (tmo_q == TW'(TIMEOUT_TICKS - 1)) tmo_hit = 1'b1;
      else                                 tmo_d   = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_TICKS;
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    inh_d     = inh_q;
    shift_d   = shift_q;
    edges_d   = edges_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    ack_d     = ack_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx.tx_valid) begin
          shift_d  = {~^tx.tx_data, tx.tx_data};
          inh_d    = '0;
          clk_oe_d = 1'b1;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (clk_en) begin
          if (inh_q == IW'(INHIBIT_TICKS - 1)) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b1;
            state_d   = S_START;
          end else begin
            inh_d = inh_q + 1'b1;
          end
        end
      end
      S_START: begin
        edges_d = '0;
        state_d = S_XFER;
      end
      S_XFER: begin
        if (fall) begin
          edges_d = edges_q + 4'd1;
          if (edges_q < 4'd9) begin
            data_oe_d = ~shift_q[0];
            shift_d   = {1'b0, shift_q[8:1]};
          end else if (edges_q == 4'd9) begin
            data_oe_d = 1'b0;
          end else begin
            ack_d   = ~data_s2_q;
            state_d = S_WAIT_IDLE;
          end
        end else if (tmo_hit) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_s2_q && data_s2_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (tmo_hit) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q   <= S_IDLE;
      inh_q     <= '0;
      shift_q   <= '0;
      edges_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      inh_q     <= inh_d;
      shift_q   <= shift_d;
      edges_q   <= edges_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  assign tx.tx_ready = (state_q == S_IDLE);
  assign tx.done     = done_q;
  assign tx.ack_ok   = ack_q;
  assign tx.error    = err_q;
  assign rx_inhibit  = (state_q != S_IDLE);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: open-drain bus, behavioural PS/2 device,
// expected frames queued at acceptance and checked when done/error appears.
module tb_ps2_host_tx;
  localparam int unsigned INH = 120;
  localparam int unsigned TMO = 200;
  localparam int unsigned H   = 40;   // device half-period in clk cycles

  logic clk = 1'b0;
  logic nRESET = 1'b0;
  logic clk_en = 1'b0;
  logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe, rx_inhibit;
  logic dev_clk_low = 1'b0, dev_data_low = 1'b0;

  ps2_host_tx_if bus ();

  ps2_host_tx #(.INHIBIT_TICKS(INH), .TIMEOUT_TICKS(TMO)) dut (
    .clk         (clk),
    .nRESET      (nRESET),
    .clk_en      (clk_en),
    .tx          (bus.slave),
    .rx_inhibit  (rx_inhibit),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       ack;
    logic       err;
    logic       par;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int checks = 0, failures = 0, resp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Behavioural device: clocks 11 falling edges, samples the host's bit at the
  // end of each low phase, optionally pulls ACK low across edge 11.
  logic        dev_ack = 1'b1, dev_mute = 1'b0, dev_abort = 1'b0;
  int          dev_edges = 0;
  logic [11:1] cap = '0;

  task automatic dev_wait(input int n);
    for (int i = 0; i < n && !dev_abort; i++) @(negedge clk);
  endtask

  initial begin : device
    forever begin
      @(negedge clk);
      if (!dev_mute && !dev_abort && nRESET && ps2_clk_in && !ps2_data_in && !ps2_clk_oe) begin
        dev_edges = 0;
        dev_wait(H);
        for (int k = 1; k <= 11 && !dev_abort; k++) begin
          dev_clk_low = 1'b1;
          dev_edges   = k;
          dev_wait(H);
          cap[k]      = ps2_data_in;
          dev_clk_low = 1'b0;
          if (k == 10) dev_data_low = dev_ack;
          if (k == 11) dev_data_low = 1'b0;
          dev_wait(H);
        end
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
      end
    end
  end

  // Strobe generator plus inhibit-length and watchdog-length measurement.
  int   div = 0, meas = 0, tmo_meas = 0;
  logic oe_prev = 1'b0, xfer_prev = 1'b0;

  always @(negedge clk) begin
    if (clk_en && oe_prev)   meas++;
    if (clk_en && xfer_prev) tmo_meas++;
    if (!oe_prev && ps2_clk_oe) meas = 0;
    if (oe_prev && !ps2_clk_oe && nRESET) begin
      chk("start_overlap_data_oe", ps2_data_oe, 1);
      chk("inhibit_strobes", meas, INH);
      tmo_meas = 0;
    end
    if (bus.error) chk("timeout_strobes", tmo_meas, TMO);
    xfer_prev = rx_inhibit && !ps2_clk_oe && !(oe_prev && !ps2_clk_oe);
    oe_prev   = ps2_clk_oe;
    clk_en    = (div == 3);
    div       = (div + 1) % 4;
  end

  // Monitor: pops one expectation per done/error pulse.
  always @(negedge clk) begin
    if (bus.done || bus.error) begin
      resp_cnt++;
      chk("done_error_exclusive", {bus.done, bus.error} == 2'b11, 0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_response done=%0b error=%0b required=none", bus.done, bus.error);
      end else begin
        e = exp_q.pop_front();
        chk("error_pulse", bus.error, e.err);
        chk("lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("tx_ready_after", bus.tx_ready, 1);
        chk("rx_inhibit_after", rx_inhibit, 0);
        if (!e.err) begin
          chk("ack_ok", bus.ack_ok, e.ack);
          chk("data_bits", cap[8:1], e.data);
          chk("parity_bit", cap[9], e.par);
          chk("stop_bit", cap[10], 1);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic ack, input logic err, input logic push);
    int t = 0;
    while (!bus.tx_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("ready_before_send", bus.tx_ready, 1);
    dev_ack      = ack;
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    if (push) exp_q.push_back('{data: d, ack: ack, err: err, par: ($countones(d) % 2 == 0)});
    @(negedge clk);
    bus.tx_valid = 1'b0;
    chk("accept_ready_drop", bus.tx_ready, 0);
    chk("accept_clk_oe", ps2_clk_oe, 1);
  endtask

  task automatic wait_resp(input int target);
    int t = 0;
    while (resp_cnt < target && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("response_seen", resp_cnt, target);
  endtask

  task automatic wait_edge(input int n);
    int t = 0;
    while (dev_edges != n && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("device_edge_reached", dev_edges, n);
  endtask

  int exp_n = 0;
  int stray = 0;
  logic [7:0] rd;
  logic ra;

  initial begin : stimulus
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    chk("rst_tx_ready", bus.tx_ready, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_ack_ok", bus.ack_ok, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_rx_inhibit", rx_inhibit, 0);
    nRESET = 1'b1;
    repeat (2) @(negedge clk);

    send(8'hED, 1'b1, 1'b0, 1'b1); wait_resp(++exp_n);
    send(8'hF4, 1'b1, 1'b0, 1'b1); wait_resp(++exp_n);
    send(8'hA7, 1'b0, 1'b0, 1'b1); wait_resp(++exp_n);

    // Request while busy must be dropped, not queued.
    send(8'hED, 1'b1, 1'b0, 1'b1);
    wait_edge(3);
    bus.tx_data  = 8'h55;
    bus.tx_valid = 1'b1;
    repeat (200) @(negedge clk);
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    wait_resp(++exp_n);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ps2_clk_oe || rx_inhibit) stray++;
    end
    chk("no_stray_transfer", stray, 0);

    // Reset mid-frame releases both lines at once.
    send(8'h3C, 1'b1, 1'b0, 1'b0);
    wait_edge(5);
    dev_abort = 1'b1;
    nRESET    = 1'b0;
    #1;
    chk("midrst_lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
    chk("midrst_tx_ready", bus.tx_ready, 1);
    chk("midrst_rx_inhibit", rx_inhibit, 0);
    @(negedge clk);
    nRESET = 1'b1;
    repeat (2 * H) @(negedge clk);
    dev_abort = 1'b0;
    send(8'h5A, 1'b1, 1'b0, 1'b1); wait_resp(++exp_n);

    for (int i = 0; i < 5; i++) begin
      rd = 8'($urandom_range(0, 255));
      ra = 1'($urandom_range(0, 1));
      send(rd, ra, 1'b0, 1'b1);
      wait_resp(++exp_n);
    end

`ifdef PS2_HOST_TX_TIMEOUT_EN
    dev_mute = 1'b1;
    send(8'h81, 1'b1, 1'b1, 1'b1);
    wait_resp(++exp_n);
    dev_mute = 1'b0;
`endif

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
